// File: rtl/dut_sweep_misr_pkg.sv
// Shared types and defaults for the sweep-and-signature engine.
// No logic; holds the FSM state encoding, the default MISR taps and default widths.
// Imported by misr_step and dut_sweep_misr.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } sweep_state_t;

    // x^23 + x^5 + 1
    localparam logic [22:0] MISR_POLY_23 = 23'h000021;

    localparam int DEF_IN_W          = 4;
    localparam int DEF_OUT_W         = 23;
    localparam int DEF_SETTLE_CYCLES = 1;

endpackage

// File: rtl/dut_sweep_misr_misr_step.sv
// One MISR step: shift left, fold in the feedback taps when the MSB falls out, xor in data.
// Purely combinational, zero latency; the caller registers sig_next.
// No flow control; the caller decides when the step is taken.
module misr_step
    import sweep_pkg::*;
#(
    parameter int               OUT_W     = DEF_OUT_W,
    parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(MISR_POLY_23)
) (
    input  logic [OUT_W-1:0] sig,
    input  logic [OUT_W-1:0] data,
    output logic [OUT_W-1:0] sig_next
);

    // Galois-style shift with feedback taken from the outgoing MSB.
    always_comb begin
        sig_next = {sig[OUT_W-2:0], 1'b0} ^ data;
        if (sig[OUT_W-1]) begin
            sig_next = sig_next ^ MISR_POLY;
        end
    end

endmodule

// File: rtl/dut_sweep_misr.sv
// Sweeps dut_in over 0..2^IN_W-1, captures dut_out after a settle window, folds it into a MISR.
// One vector every SETTLE_CYCLES+1 cycles; done rises one cycle after the final capture.
// No backpressure: abort ends the sweep early; start is ignored while busy.
module dut_sweep_misr
    import sweep_pkg::*;
#(
    parameter int               IN_W          = DEF_IN_W,
    parameter int               OUT_W         = DEF_OUT_W,
    parameter int               SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter logic [OUT_W-1:0] MISR_POLY     = OUT_W'(MISR_POLY_23)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             sample_valid,
    output logic [IN_W-1:0]  sample_idx,
    output logic [OUT_W-1:0] sample_data,
    output logic [OUT_W-1:0] signature
);

    localparam logic [7:0]      SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [IN_W-1:0] LAST_VEC      = '1;

    sweep_state_t     state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IN_W-1:0]  dut_in_q, dut_in_d;
    logic [OUT_W-1:0] sig_q, sig_d;
    logic             done_q, done_d;
    logic             sample_valid_q, sample_valid_d;
    logic [IN_W-1:0]  sample_idx_q, sample_idx_d;
    logic [OUT_W-1:0] sample_data_q, sample_data_d;
    logic [OUT_W-1:0] sig_next;

    misr_step #(
        .OUT_W     (OUT_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr_step (
        .sig      (sig_q),
        .data     (dut_out),
        .sig_next (sig_next)
    );

    // Next-state and next-register values; abort outranks start and the sweep itself.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dut_in_d       = dut_in_q;
        sig_d          = sig_q;
        done_d         = done_q;
        sample_valid_d = 1'b0;
        sample_idx_d   = sample_idx_q;
        sample_data_d  = sample_data_q;

        case (state_q)
            IDLE, DONE: begin
                // done lags entry into DONE by one cycle so the signature is already final.
                done_d = (state_q == DONE);
                if (start) begin
                    state_d  = SETTLE;
                    dut_in_d = '0;
                    sig_d    = '0;
                    cnt_d    = SETTLE_RELOAD;
                    done_d   = 1'b0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    sample_valid_d = 1'b1;
                    sample_idx_d   = dut_in_q;
                    sample_data_d  = dut_out;
                    sig_d          = sig_next;
                    if (dut_in_q == LAST_VEC) begin
                        state_d = DONE;
                    end else begin
                        state_d  = SETTLE;
                        dut_in_d = dut_in_q + 1'b1;
                        cnt_d    = SETTLE_RELOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            dut_in_q       <= '0;
            sig_q          <= '0;
            done_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_idx_q   <= '0;
            sample_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dut_in_q       <= dut_in_d;
            sig_q          <= sig_d;
            done_q         <= done_d;
            sample_valid_q <= sample_valid_d;
            sample_idx_q   <= sample_idx_d;
            sample_data_q  <= sample_data_d;
        end
    end

    // Busy is a pure decode of the state register, so it has no input-to-output path.
    always_comb begin
        busy = (state_q == SETTLE) || (state_q == CAPTURE);
    end

    assign dut_in       = dut_in_q;
    assign done         = done_q;
    assign sample_valid = sample_valid_q;
    assign sample_idx   = sample_idx_q;
    assign sample_data  = sample_data_q;
    assign signature    = sig_q;

endmodule

// File: tb/tb_dut_sweep_misr.sv
// Directed bench for dut_sweep_misr with default parameters.
// Stub responses are selected by mode; expected signatures are hand-computed constants,
// except the stand-in combinational design, whose signature comes from a reference MISR loop.
module tb_dut_sweep_misr;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  dut_in;
    logic [22:0] dut_out;
    logic        busy;
    logic        done;
    logic        sample_valid;
    logic [3:0]  sample_idx;
    logic [22:0] sample_data;
    logic [22:0] signature;

    int errors = 0;
    int checks = 0;
    int mode   = 0;

    dut_sweep_misr u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .dut_in       (dut_in),
        .dut_out      (dut_out),
        .busy         (busy),
        .done         (done),
        .sample_valid (sample_valid),
        .sample_idx   (sample_idx),
        .sample_data  (sample_data),
        .signature    (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the generated combinational design.
    function automatic logic [22:0] design_model(input logic [3:0] x);
        logic [2:0] lo;
        lo = x[2:0] ^ 3'b101;
        return {x, ~x, x ^ 4'h9, x, lo, x};
    endfunction

    // Stub responses per mode.
    function automatic logic [22:0] stub_val(input int m, input logic [3:0] x);
        case (m)
            1:       return (x == 4'd15) ? 23'h000001 : 23'h0;
            2:       return (x == 4'd14) ? 23'h000001 : 23'h0;
            3:       return (x == 4'd0)  ? 23'h000001 : 23'h0;
            4:       return (x == 4'd14) ? 23'h400000 : 23'h0;
            5:       return 23'h000001;
            6:       return design_model(x);
            default: return 23'h0;
        endcase
    endfunction

    always_comb dut_out = stub_val(mode, dut_in);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dut_in"}, 32'(dut_in), 32'h0);
        chk({tag, "_sig"},    32'(signature), 32'h0);
        chk({tag, "_busy"},   32'(busy), 32'h0);
        chk({tag, "_done"},   32'(done), 32'h0);
        chk({tag, "_sv"},     32'(sample_valid), 32'h0);
        chk({tag, "_idx"},    32'(sample_idx), 32'h0);
        chk({tag, "_data"},   32'(sample_data), 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full sweep: start sampled at edge 0, captures at even edges 2..32, done at edge 33.
    task automatic sweep(input int m, input logic [22:0] exp_sig, input string tag);
        int k;
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_start_dut_in"}, 32'(dut_in), 32'h0);
        chk({tag, "_start_sig"},    32'(signature), 32'h0);
        chk({tag, "_start_busy"},   32'(busy), 32'h1);
        for (int e = 1; e <= 33; e++) begin
            tick();
            if ((e % 2 == 0) && (e <= 32)) begin
                k = e / 2 - 1;
                chk($sformatf("%s_sv_e%0d", tag, e),  32'(sample_valid), 32'h1);
                chk($sformatf("%s_idx_e%0d", tag, e), 32'(sample_idx), 32'(k));
                chk($sformatf("%s_data_e%0d", tag, e), 32'(sample_data),
                    32'(stub_val(m, 4'(k))));
            end else begin
                chk($sformatf("%s_sv_e%0d", tag, e), 32'(sample_valid), 32'h0);
            end
            if (e == 32) chk({tag, "_done_e32"}, 32'(done), 32'h0);
            if (e == 33) begin
                chk({tag, "_done_e33"}, 32'(done), 32'h1);
                chk({tag, "_busy_e33"}, 32'(busy), 32'h0);
                chk({tag, "_sig"},      32'(signature), 32'(exp_sig));
            end
        end
        tick();
        chk({tag, "_done_held"}, 32'(done), 32'h1);
        chk({tag, "_sig_held"},  32'(signature), 32'(exp_sig));
    endtask

    initial begin
        logic [22:0] model_sig;

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 0;
        @(negedge clk);
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        sweep(0, 23'h000000, "zero");
        sweep(1, 23'h000001, "v15");
        sweep(2, 23'h000002, "v14");
        sweep(3, 23'h008000, "v0");
        sweep(4, 23'h000021, "fbk");

        // Control scenario with dut_out = 1 everywhere.
        mode  = 5;
        start = 1'b1;
        tick();                        // edge 0
        start = 1'b0;
        chk("ctl_done_cleared", 32'(done), 32'h0);
        repeat (9) tick();             // through edge 9
        start = 1'b1;
        tick();                        // edge 10: restart ignored
        start = 1'b0;
        chk("ctl_restart_dut_in", 32'(dut_in), 32'h5);
        chk("ctl_restart_busy",   32'(busy), 32'h1);
        chk("ctl_restart_sig",    32'(signature), 32'h00001F);
        repeat (2) tick();             // through edge 12
        chk("ctl_e12_sig", 32'(signature), 32'h00003F);
        abort = 1'b1;
        start = 1'b1;
        tick();                        // edge 13: abort wins
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy",   32'(busy), 32'h0);
        chk("abort_dut_in", 32'(dut_in), 32'h6);
        chk("abort_sig",    32'(signature), 32'h00003F);
        chk("abort_done",   32'(done), 32'h0);
        chk("abort_sv",     32'(sample_valid), 32'h0);
        abort = 1'b1;                  // abort in IDLE is ignored
        repeat (3) tick();
        abort = 1'b0;
        chk("idle_dut_in", 32'(dut_in), 32'h6);
        chk("idle_sig",    32'(signature), 32'h00003F);
        chk("idle_busy",   32'(busy), 32'h0);
        chk("idle_done",   32'(done), 32'h0);

        sweep(5, 23'h00FFFF, "ones");

        // Reset mid-sweep overrides start and abort.
        mode  = 5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("pre_rst_busy", 32'(busy), 32'h1);
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        check_all_zero("midrst");
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'h0);

        // Stand-in design against a reference signature.
        model_sig = 23'h0;
        for (int x = 0; x < 16; x++) begin
            logic [22:0] nxt;
            nxt = {model_sig[21:0], 1'b0} ^ design_model(4'(x));
            if (model_sig[22]) nxt = nxt ^ 23'h000021;
            model_sig = nxt;
        end
        sweep(6, model_sig, "design");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
